writeback_arb: RTL

WRITEBACK_ARB -- requirements
Module: writeback_arb

---
 rtl/writeback_arb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/writeback_arb.sv
// Writeback arbiter: picks one execute-unit result per cycle by round-robin,
// holds it for one cycle in the W stage, then drives the register-file write
// port and the completion (commit) notification from that stage register.
module writeback_arb #(
  parameter int p_num_pipes    = 2,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [p_num_pipes-1:0]                       X_val,
  output logic [p_num_pipes-1:0]                       X_rdy,
  input  logic [p_num_pipes-1:0][31:0]                 X_pc,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]   X_seq_num,
  input  logic [p_num_pipes-1:0][4:0]                  X_waddr,
  input  logic [p_num_pipes-1:0][31:0]                 X_wdata,
  input  logic [p_num_pipes-1:0]                       X_wen,
  output logic                                         rf_wen,
  output logic [4:0]                                   rf_waddr,
  output logic [31:0]                                  rf_wdata,
  output logic                                         cmt_val,
  output logic [31:0]                                  cmt_pc,
  output logic [p_seq_num_bits-1:0]                    cmt_seq_num
);

  // Pointer width; a single unit still gets a 1-bit pointer that stays at 0.
  localparam int                  c_ptr_bits = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
  localparam logic [c_ptr_bits:0] c_num      = (c_ptr_bits + 1)'(p_num_pipes);

  // Arbitration state and W-stage register
  logic [c_ptr_bits-1:0]     rr_ptr_r;
  logic                      w_val_r;
  logic                      w_rf_wen_r;
  logic [31:0]               w_pc_r;
  logic [p_seq_num_bits-1:0] w_seq_num_r;
  logic [4:0]                w_waddr_r;
  logic [31:0]               w_wdata_r;

  // Arbitration results
  logic                      grant_any_s;
  logic [c_ptr_bits-1:0]     grant_idx_s;
  logic [c_ptr_bits:0]       cand_s;
  logic [c_ptr_bits:0]       ptr_inc_s;
  logic [c_ptr_bits-1:0]     next_ptr_s;

  // Round-robin search: first valid unit at or after rr_ptr, wrapping to 0.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int off = 0; off < p_num_pipes; off++) begin
      cand_s = {1'b0, rr_ptr_r} + (c_ptr_bits + 1)'(off);
      if (cand_s >= c_num) begin
        cand_s = cand_s - c_num;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_any_s && X_val[cand_s[c_ptr_bits-1:0]]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s[c_ptr_bits-1:0];
      end else begin
        grant_any_s = grant_any_s;
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Pointer advances to the unit after the winner, wrapping at p_num_pipes.
  always_comb begin
    ptr_inc_s = {1'b0, grant_idx_s} + {{c_ptr_bits{1'b0}}, 1'b1};
    if (ptr_inc_s >= c_num) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = ptr_inc_s[c_ptr_bits-1:0];
    end
  end

  // One-hot accept to the winner only; nothing is accepted while in reset.
  always_comb begin
    X_rdy = '0;
    if (rst) begin
      X_rdy = '0;
    end else if (grant_any_s) begin
      X_rdy[grant_idx_s] = 1'b1;
    end else begin
      X_rdy = '0;
    end
  end

  // Control state: W valid, qualified write enable and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_val_r    <= 1'b0;
      w_rf_wen_r <= 1'b0;
      rr_ptr_r   <= '0;
    end else begin
      w_val_r    <= grant_any_s;
      // Write enable is qualified here so rf_wen leaves a flop; x0 is never written.
      w_rf_wen_r <= grant_any_s & X_wen[grant_idx_s] & (X_waddr[grant_idx_s] != 5'd0);
      if (grant_any_s) begin
        rr_ptr_r <= next_ptr_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Payload of the W stage; contents are meaningless while w_val_r is low.
  always_ff @(posedge clk) begin
    if (grant_any_s) begin
      w_pc_r      <= X_pc[grant_idx_s];
      w_seq_num_r <= X_seq_num[grant_idx_s];
      w_waddr_r   <= X_waddr[grant_idx_s];
      w_wdata_r   <= X_wdata[grant_idx_s];
    end else begin
      w_pc_r      <= w_pc_r;
      w_seq_num_r <= w_seq_num_r;
      w_waddr_r   <= w_waddr_r;
      w_wdata_r   <= w_wdata_r;
    end
  end

  assign rf_wen      = w_rf_wen_r;
  assign rf_waddr    = w_waddr_r;
  assign rf_wdata    = w_wdata_r;
  assign cmt_val     = w_val_r;
  assign cmt_pc      = w_pc_r;
  assign cmt_seq_num = w_seq_num_r;

endmodule
